pwm_modport: RTL and testbench



---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_counter.sv | 60 ++++++
 rtl/pwm_modport.sv | 68 ++++++
 tb/tb_pwm_modport.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the single-channel PWM block.
// The top-level width and the counter width both default to PWM_WIDTH.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef logic [PWM_WIDTH-1:0] pwm_cnt_t;

endpackage : pwm_pkg

// File: rtl/pwm_counter.sv
// Period counter for the PWM block: tracks position within the period and the run state.
// The counter wraps by comparing against the period limit, so it never overflows.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] range_val,
  output logic [WIDTH-1:0] cnt,
  output logic             running,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic             running_r;
  logic             running_s;
  logic             at_limit_s;

  assign at_limit_s = (cnt_r == range_val);

  // Next-state logic for the counter and run flag
  always_comb begin
    cnt_s     = cnt_r;
    running_s = running_r;
    if (!en) begin
      cnt_s     = {WIDTH{1'b0}};
      running_s = 1'b0;
    end else if (!running_r) begin
      cnt_s     = {WIDTH{1'b0}};
      running_s = 1'b1;
    end else if (at_limit_s) begin
      cnt_s     = {WIDTH{1'b0}};
      running_s = 1'b1;
    end else begin
      cnt_s     = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
      running_s = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= {WIDTH{1'b0}};
      running_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      running_r <= running_s;
    end
  end

  assign cnt     = cnt_r;
  assign running = running_r;
  // Terminal count only means something while a period is actually running
  assign tc      = running_r && at_limit_s;

endmodule : pwm_counter

// File: rtl/pwm_modport.sv
// 8-bit PWM channel: shadowed duty/period settings, period counter and output compare.
// Settings are picked up while idle or at a period boundary, so a period is never torn.
module pwm_modport
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pwm_value,
  input  logic [WIDTH-1:0] pwm_range,
  input  logic             pwm_en,
  output logic             pwm_period,
  output logic             pwm_out
);

  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] value_s;
  logic [WIDTH-1:0] range_r;
  logic [WIDTH-1:0] range_s;
  logic [WIDTH-1:0] cnt_s;
  logic             running_s;
  logic             tc_s;

  pwm_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (pwm_en),
    .range_val (range_r),
    .cnt       (cnt_s),
    .running   (running_s),
    .tc        (tc_s)
  );

  // Shadow load: follow the inputs while idle, otherwise only at the period boundary
  always_comb begin
    value_s = value_r;
    range_s = range_r;
    if (!pwm_en) begin
      value_s = pwm_value;
      range_s = pwm_range;
    end else if (tc_s) begin
      value_s = pwm_value;
      range_s = pwm_range;
    end else begin
      value_s = value_r;
      range_s = range_r;
    end
  end

  // Shadow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      value_r <= {WIDTH{1'b0}};
      range_r <= {WIDTH{1'b0}};
    end else begin
      value_r <= value_s;
      range_r <= range_s;
    end
  end

  // Outputs decode registered state only, so they cannot glitch on input changes
  assign pwm_out    = running_s && (cnt_s < value_r);
  assign pwm_period = tc_s;

endmodule : pwm_modport

// File: tb/tb_pwm_modport.sv
// Directed testbench for pwm_modport with hand-computed expected waveforms.
module tb_pwm_modport;
  import pwm_pkg::*;

  logic     clk;
  logic     reset;
  pwm_cnt_t pwm_value;
  pwm_cnt_t pwm_range;
  logic     pwm_en;
  logic     pwm_period;
  logic     pwm_out;

  int n_cmp;
  int n_err;

  pwm_modport #(.WIDTH(PWM_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_value  (pwm_value),
    .pwm_range  (pwm_range),
    .pwm_en     (pwm_en),
    .pwm_period (pwm_period),
    .pwm_out    (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp_out, input logic exp_per);
    n_cmp = n_cmp + 1;
    assert (pwm_out === exp_out) else begin
      n_err = n_err + 1;
      $error("FAIL %s pwm_out observed=%b expected=%b", tag, pwm_out, exp_out);
    end
    n_cmp = n_cmp + 1;
    assert (pwm_period === exp_per) else begin
      n_err = n_err + 1;
      $error("FAIL %s pwm_period observed=%b expected=%b", tag, pwm_period, exp_per);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    pwm_en    = 1'b0;
    pwm_value = 8'd0;
    pwm_range = 8'd0;
    tick();
    tick();
    chk("reset", 1'b0, 1'b0);

    // value=64 range=255: load shadows while idle, then run one full period
    reset     = 1'b0;
    pwm_value = 8'd64;
    pwm_range = 8'd255;
    tick();
    chk("idle_load", 1'b0, 1'b0);
    pwm_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      chk("v64_r255", (k < 64), (k == 255));
    end
    tick();
    chk("v64_r255_wrap", 1'b1, 1'b0);

    // value=3 range=3 -> 1,1,1,0
    pwm_en    = 1'b0;
    pwm_value = 8'd3;
    pwm_range = 8'd3;
    tick();
    chk("dis_v3", 1'b0, 1'b0);
    pwm_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("v3_r3", ((k % 4) < 3), ((k % 4) == 3));
    end

    // value=10 range=3 -> always high
    pwm_en    = 1'b0;
    pwm_value = 8'd10;
    pwm_range = 8'd3;
    tick();
    chk("dis_v10", 1'b0, 1'b0);
    pwm_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("v10_r3", 1'b1, ((k % 4) == 3));
    end

    // value=0 range=3 -> always low, strobe still pulses
    pwm_en    = 1'b0;
    pwm_value = 8'd0;
    pwm_range = 8'd3;
    tick();
    pwm_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("v0_r3", 1'b0, ((k % 4) == 3));
    end

    // range=0 value=1 -> both high every running cycle
    pwm_en    = 1'b0;
    pwm_value = 8'd1;
    pwm_range = 8'd0;
    tick();
    pwm_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("v1_r0", 1'b1, 1'b1);
    end

    // value=8 range=15, value changed to 2 at cnt=5: applies from next period
    pwm_en    = 1'b0;
    pwm_value = 8'd8;
    pwm_range = 8'd15;
    tick();
    pwm_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("mid_change_p1", (k < 8), (k == 15));
      if (k == 5) pwm_value = 8'd2;
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("mid_change_p2", (k < 2), (k == 15));
    end

    // Drop enable at cnt=7, then re-enable with new settings
    pwm_en    = 1'b0;
    pwm_value = 8'd12;
    pwm_range = 8'd15;
    tick();
    pwm_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("pre_drop", 1'b1, 1'b0);
    end
    pwm_en    = 1'b0;
    pwm_value = 8'd5;
    pwm_range = 8'd7;
    tick();
    chk("drop_en", 1'b0, 1'b0);
    tick();
    chk("drop_en_hold", 1'b0, 1'b0);
    pwm_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("reenable", (k < 5), (k == 7));
    end

    // Reset mid-period with enable held high
    reset = 1'b1;
    tick();
    chk("mid_reset", 1'b0, 1'b0);
    reset = 1'b0;
    // shadows are zero after reset: first period is 1 cycle with duty 0
    tick();
    chk("post_reset_first", 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_reset_v5_r7", (k < 5), (k == 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pwm_modport
